// File: rtl/pixel_frame_packer.sv
// rtl/pixel_frame_packer.sv - binarises a grayscale pixel stream and packs ROWS*COLS bits per output frame
//
// Ports:
//   clk_i        clock, rising edge
//   reset_ni     asynchronous active-low reset
//   pix_valid_i  upstream pixel valid
//   pix_data_i   unsigned pixel value
//   pix_sof_i    first pixel of a frame, qualified by the pixel handshake
//   pix_ready_o  block can accept a pixel
//   valid_o      packed frame valid
//   data_o       packed frame, bit k = pixel k (k = row*COLS + col)
//   ready_i      downstream ready
//   resync_o     one-cycle pulse when a partial frame is discarded
//   frame_cnt_o  frames delivered, wraps 255 -> 0
module pixel_frame_packer #(
   parameter int ROWS   = 28,
   parameter int COLS   = 28,
   parameter int PIX_W  = 8,
   parameter int THRESH = 128
) (
   input  logic                   clk_i,
   input  logic                   reset_ni,
   input  logic                   pix_valid_i,
   input  logic [PIX_W-1:0]       pix_data_i,
   input  logic                   pix_sof_i,
   output logic                   pix_ready_o,
   output logic                   valid_o,
   output logic [ROWS*COLS-1:0]   data_o,
   input  logic                   ready_i,
   output logic                   resync_o,
   output logic [7:0]             frame_cnt_o
);

   localparam int N     = ROWS * COLS;
   localparam int IDX_W = $clog2(N);

   logic [N-1:0]     asm_q;
   logic [IDX_W-1:0] idx;
   logic             asm_full;

   logic             pix_bit;
   logic             accept;
   logic             drain;
   logic             do_resync;
   logic             do_last;
   logic             load_direct;
   logic             asm_full_n;
   logic [N-1:0]     frame_word;

   // Thresholds outside the pixel range are resolved at elaboration so the
   // compare never has to be wider than the pixel itself.
   generate
      if (THRESH <= 0) begin : g_thr_low
         assign pix_bit = 1'b1;
      end else if (THRESH > (2 ** PIX_W) - 1) begin : g_thr_high
         assign pix_bit = 1'b0;
      end else begin : g_thr_mid
         assign pix_bit = (pix_data_i >= PIX_W'(THRESH));
      end
   endgenerate

   always_comb begin
      accept      = pix_valid_i && pix_ready_o;
      drain       = valid_o && ready_i;
      // A SOF in the middle of a frame wins over completion, even at idx N-1.
      do_resync   = accept && pix_sof_i && (idx != '0);
      do_last     = accept && !do_resync && (idx == IDX_W'(N - 1));
      // The last bit bypasses the assembly buffer so the frame lands in one edge.
      frame_word         = asm_q;
      frame_word[N-1]    = pix_bit;
      load_direct = do_last && (!valid_o || ready_i);
      asm_full_n  = asm_full;
      if (asm_full && ready_i) begin
         asm_full_n = 1'b0;
      end
      if (do_last && !load_direct) begin
         asm_full_n = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         asm_q       <= '0;
         idx         <= '0;
         asm_full    <= 1'b0;
         pix_ready_o <= 1'b0;
         valid_o     <= 1'b0;
         data_o      <= '0;
         resync_o    <= 1'b0;
         frame_cnt_o <= '0;
      end else begin
         resync_o    <= do_resync;
         asm_full    <= asm_full_n;
         // Registered from the next-state of asm_full: no path from ready_i.
         pix_ready_o <= !asm_full_n;

         if (drain) begin
            frame_cnt_o <= frame_cnt_o + 8'd1;
         end

         if (accept) begin
            if (do_resync) begin
               asm_q[0] <= pix_bit;
               idx      <= IDX_W'(1);
            end else if (do_last) begin
               idx <= '0;
               if (!load_direct) begin
                  asm_q[N-1] <= pix_bit;
               end
            end else begin
               asm_q[idx] <= pix_bit;
               idx        <= idx + 1'b1;
            end
         end

         if (load_direct) begin
            data_o  <= frame_word;
            valid_o <= 1'b1;
         end else if (asm_full && ready_i) begin
            data_o  <= asm_q;
            valid_o <= 1'b1;
         end else if (drain) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pixel_frame_packer.sv
// tb/tb_pixel_frame_packer.sv - scoreboard bench for pixel_frame_packer
module tb_pixel_frame_packer;

   localparam int N      = 784;
   localparam int THRESH = 128;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           pix_valid = 1'b0;
   logic [7:0]     pix_data = 8'd0;
   logic           pix_sof = 1'b0;
   logic           pix_ready_o;
   logic           valid_o;
   logic [N-1:0]   data_o;
   logic           ready = 1'b0;
   logic           resync_o;
   logic [7:0]     frame_cnt_o;

   int             checks = 0;
   int             errors = 0;
   int             cyc = 0;
   logic [N-1:0]   sb_q[$];
   int             pop_cyc[$];
   int             midx = 0;
   logic [N-1:0]   mframe = '0;
   int             exp_resync = 0;
   int             resync_seen = 0;
   logic [N-1:0]   exp_alt;
   logic [N-1:0]   exp_thr;

   pixel_frame_packer #(
      .ROWS(28), .COLS(28), .PIX_W(8), .THRESH(THRESH)
   ) dut (
      .clk_i       (clk),
      .reset_ni    (rst_n),
      .pix_valid_i (pix_valid),
      .pix_data_i  (pix_data),
      .pix_sof_i   (pix_sof),
      .pix_ready_o (pix_ready_o),
      .valid_o     (valid_o),
      .data_o      (data_o),
      .ready_i     (ready),
      .resync_o    (resync_o),
      .frame_cnt_o (frame_cnt_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer: a handshake visible at the negedge completes on the next rising edge.
   always @(negedge clk) begin
      if (resync_o) resync_seen++;
      if (valid_o && ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_underflow", {{(N-1){1'b0}}, valid_o}, '0);
         end else begin
            chk("sb_frame", data_o, sb_q.pop_front());
            pop_cyc.push_back(cyc);
         end
      end
   end

   task automatic send_pix(input logic [7:0] d, input logic s);
      int n;
      logic b;
      pix_valid = 1'b1;
      pix_data  = d;
      pix_sof   = s;
      @(negedge clk);
      n = 0;
      while (!pix_ready_o && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) chk("pix_ready_timeout", {{(N-1){1'b0}}, pix_ready_o}, 1);
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      b = (int'(d) >= THRESH);
      if (s && midx != 0) begin
         exp_resync++;
         mframe    = '0;
         mframe[0] = b;
         midx      = 1;
      end else begin
         mframe[midx] = b;
         if (midx == N - 1) begin
            sb_q.push_back(mframe);
            midx = 0;
         end else begin
            midx++;
         end
      end
   endtask

   task automatic send_rand_frame();
      for (int k = 0; k < N; k++) send_pix(8'($urandom_range(0, 255)), k == 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      exp_alt = {392{2'b10}};
      exp_thr = {196{4'b0110}};

      // Reset state
      #12;
      chk("rst_valid", valid_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_resync", resync_o, 0);
      chk("rst_cnt", frame_cnt_o, 0);
      chk("rst_pix_ready", pix_ready_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_pix_ready", pix_ready_o, 1);

      // Single frame, alternating pixels
      ready = 1'b1;
      for (int k = 0; k < N; k++) send_pix((k % 2) ? 8'd200 : 8'd10, k == 0);
      chk("single_valid", valid_o, 1);
      chk("single_data", data_o, exp_alt);
      @(posedge clk);
      #1;
      chk("single_cnt", frame_cnt_o, 1);
      chk("single_valid_drop", valid_o, 0);

      // Backpressure
      ready = 1'b0;
      send_rand_frame();
      send_rand_frame();
      chk("bp_pix_ready_low", pix_ready_o, 0);
      chk("bp_valid", valid_o, 1);
      chk("bp_hold", data_o, sb_q[0]);
      chk("bp_cnt1", frame_cnt_o, 1);
      ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_valid_kept", valid_o, 1);
      chk("bp_frame2", data_o, sb_q[0]);
      chk("bp_pix_ready_back", pix_ready_o, 1);
      chk("bp_cnt2", frame_cnt_o, 2);
      @(posedge clk);
      #1;
      chk("bp_cnt3", frame_cnt_o, 3);
      chk("bp_valid_drop", valid_o, 0);

      // Resync
      for (int k = 0; k < 300; k++) send_pix(8'd255, 1'b0);
      send_pix(8'd0, 1'b1);
      chk("resync_pulse", resync_o, 1);
      for (int k = 1; k < N; k++) send_pix(8'd0, 1'b0);
      chk("resync_once", resync_seen, exp_resync);
      chk("resync_count", resync_seen, 1);
      chk("resync_valid", valid_o, 1);
      chk("resync_zero", data_o, '0);
      repeat (2) @(posedge clk);
      #1;
      chk("resync_cnt", frame_cnt_o, 4);

      // Threshold edges, held on the output
      ready = 1'b0;
      for (int k = 0; k < N; k++) begin
         case (k % 4)
            0: send_pix(8'd127, 1'b0);
            1: send_pix(8'd128, 1'b0);
            2: send_pix(8'd255, 1'b0);
            default: send_pix(8'd0, 1'b0);
         endcase
      end
      chk("thr_data", data_o, exp_thr);

      // Async reset mid-frame while a frame is held on the output
      for (int k = 0; k < 500; k++) send_pix(8'($urandom_range(0, 255)), 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", valid_o, 0);
      chk("arst_data", data_o, 0);
      chk("arst_cnt", frame_cnt_o, 0);
      chk("arst_pix_ready", pix_ready_o, 0);
      sb_q.delete();
      midx = 0;
      @(negedge clk);
      chk("arst_resync", resync_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b1;
      send_rand_frame();
      repeat (2) @(posedge clk);
      #1;
      chk("arst_cnt1", frame_cnt_o, 1);

      // Streaming three frames after a fresh reset
      rst_n = 1'b0;
      midx = 0;
      #5;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      pop_cyc.delete();
      for (int f = 0; f < 3; f++) send_rand_frame();
      repeat (3) @(posedge clk);
      #1;
      chk("stream_cnt", frame_cnt_o, 3);
      chk("stream_pops", pop_cyc.size(), 3);
      if (pop_cyc.size() >= 3) begin
         chk("stream_gap1", pop_cyc[1] - pop_cyc[0], N);
         chk("stream_gap2", pop_cyc[2] - pop_cyc[1], N);
      end
      chk("sb_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pixel_frame_packer.md
Name: pixel_frame_packer

Overview:
- Upstream feeder for the binary MNIST classifier.
- Accepts a row-major stream of 8-bit grayscale pixels, one per handshake, and binarises each pixel against a threshold.
- Packs ROWS*COLS bits into one frame word and presents it on a valid/ready interface matching the classifier's 784-bit input.
- Double-buffered: while one frame waits on the output, the next frame assembles.

Parameters:
- ROWS, 28, image rows.
- COLS, 28, image columns; N = ROWS*COLS = 784 frame bits.
- PIX_W, 8, grayscale pixel width.
- THRESH, 128, binarisation threshold; bit = (pixel >= THRESH).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- pix_valid_i  in  1  upstream pixel valid.
- pix_data_i  in  PIX_W  unsigned pixel value.
- pix_sof_i  in  1  marks the first pixel of a frame; qualified by the handshake.
- pix_ready_o  out  1  block can accept a pixel.
- valid_o  out  1  packed frame valid.
- data_o  out  N  packed frame; bit k = pixel k (k = row*COLS + col).
- ready_i  in  1  downstream (classifier) ready.
- resync_o  out  1  one-cycle pulse: partial frame discarded.
- frame_cnt_o  out  8  frames delivered; wraps 255->0.

Behaviour:
- Reset (async assert, sync deassert via the flop clock):
  - valid_o=0, data_o=0, resync_o=0, frame_cnt_o=0.
  - Pixel index=0; assembly buffer empty, not full.
  - pix_ready_o=0 while reset_ni is low, 1 from the first cycle after release.
- Pixel accept: pix_valid_i && pix_ready_o at a clock edge.
  - Writes asm[idx] = (pix_data_i >= THRESH).
  - idx increments; idx width = clog2(N).
- SOF handling:
  - Accepted pixel with pix_sof_i=1 and idx!=0: the partial frame is discarded, the pixel is stored as index 0, idx=1, and resync_o pulses high for the next cycle.
  - SOF with idx==0: normal, no pulse.
  - SOF is optional; frames without it are delimited by count alone.
- Frame completion: the accepted pixel with idx==N-1 completes the frame and idx wraps to 0.
  - If the output register is empty, or is being drained the same cycle (valid_o && ready_i), the frame, including its last bit, loads into data_o. valid_o=1 on the next cycle. Latency is 1 cycle after the last pixel handshake.
  - Otherwise asm_full is set and pix_ready_o=0. On the first edge where the output drains, asm moves to data_o, valid_o stays 1, asm_full clears, and pix_ready_o=1 the following cycle.
- pix_ready_o = !asm_full (registered state only; no combinational path from ready_i).
- Output handshake:
  - data_o and valid_o are held stable while valid_o && !ready_i.
  - On valid_o && ready_i with no new frame loading: valid_o=0 next cycle; data_o keeps its last value (don't-care).
  - frame_cnt_o increments on each output handshake.
- Throughput: 1 pixel/clock sustained when ready_i stays high; back-to-back frames need no gap cycles.
- Simultaneous events:
  - Completion on the same edge as drain: the load wins and valid_o stays 1.
  - SOF on pixel N-1 position: treated as resync, so the frame does not complete.
- Reset mid-frame or mid-output: all state clears and the partial frame is lost; no resync_o pulse.
- Pixel values are unsigned compares. THRESH=0 gives all ones; THRESH > 2^PIX_W-1 gives all zeros.

Test Plan:
- Single frame, ready_i=1: 784 pixels, pixel k = (k%2)?200:10, SOF on k=0 -> valid_o one cycle after the last handshake; data_o = {392{2'b10}} (odd bits set); frame_cnt_o=1.
- Backpressure: hold ready_i=0 and send 2 full frames -> pix_ready_o drops after pixel 783 of frame 2; data_o holds frame 1. Raise ready_i -> frame 2 appears the next cycle and pix_ready_o returns; frame_cnt_o=1 then 2.
- Resync: send 300 pixels of 255, then SOF with pixel 0 followed by 783 pixels of 0 -> resync_o pulses once; the output frame is all zeros (no leftover ones).
- Threshold edges: pixels 127, 128, 255, 0 repeating -> bits 0,1,1,0 repeating.
- Async reset mid-frame: after 500 pixels, pulse reset_ni low between clock edges -> outputs clear immediately; the next full frame delivers correctly with frame_cnt_o=1.
- Streaming: 3 frames with pix_valid_i and ready_i always 1 -> 3 valid_o pulses spaced exactly 784 cycles apart; frame_cnt_o=3.
